// File: rtl/pll_lock_checker.sv
// Per-channel PLL lock checker: synchronises each lock input, tracks lock/loss/relock in a small FSM, and counts cycles with any error.
// Optional macro PLL_CHK_TIMEOUT_EN adds a per-channel WAIT/LOST timeout that forces FAULT.
module pll_lock_checker #(
    parameter int NUM_CH       = 4,
    parameter int SYNC_STAGES  = 3,
    parameter int RELOCK_MAX   = 1,
    parameter int ERR_CNT_W    = 3,
    parameter int LOCK_TIMEOUT = 1000
) (
    input  logic                   clk_tb,
    input  logic                   rst_n,
    input  logic [NUM_CH-1:0]      pll_lock,
    input  logic                   chk_en,
    input  logic                   clr,
    output logic [NUM_CH-1:0]      locked,
    output logic [NUM_CH-1:0]      err_chk,
    output logic [NUM_CH-1:0]      fault,
    output logic                   err_any,
    output logic [ERR_CNT_W-1:0]   results_cnt,
    output logic [3*NUM_CH-1:0]    dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_LOCKED = 3'd2,
        ST_LOST   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    localparam logic [2:0] RELOCK_LIM = 3'(RELOCK_MAX);

`ifndef PLL_CHK_TIMEOUT_EN
    localparam int unused_lock_timeout = LOCK_TIMEOUT;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   lock_s;
        logic                   lock_d;
        logic                   rise_q;
        logic                   fall_q;
        state_t                 state;
        state_t                 state_next;
        logic [2:0]             relock_cnt;
        logic [2:0]             relock_next;
        logic                   timeout;

        assign lock_s = sync_q[SYNC_STAGES-1];

        // Edge events are registered so the FSM sees them SYNC_STAGES+2 edges after the input moves.
        always_ff @(posedge clk_tb or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
                lock_d <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock[g]};
                lock_d <= lock_s;
                rise_q <= lock_s & ~lock_d;
                fall_q <= ~lock_s & lock_d;
            end
        end

`ifdef PLL_CHK_TIMEOUT_EN
        localparam int TMR_W = $clog2(LOCK_TIMEOUT + 1);
        logic [TMR_W-1:0] tmr;

        assign timeout = (tmr == TMR_W'(LOCK_TIMEOUT - 1));

        always_ff @(posedge clk_tb or negedge rst_n) begin
            if (!rst_n) begin
                tmr <= '0;
            end else if (!clr && (state_next == state) &&
                         ((state == ST_WAIT) || (state == ST_LOST))) begin
                tmr <= tmr + 1'b1;
            end else begin
                tmr <= '0;
            end
        end
`else
        assign timeout = 1'b0;
`endif

        always_ff @(posedge clk_tb or negedge rst_n) begin
            if (!rst_n) begin
                state      <= ST_IDLE;
                relock_cnt <= 3'd0;
            end else begin
                state      <= state_next;
                relock_cnt <= relock_next;
            end
        end

        // Disable beats clear, and clear beats any same-cycle lock event.
        always_comb begin
            state_next  = state;
            relock_next = relock_cnt;
            if (!chk_en) begin
                state_next  = ST_IDLE;
                relock_next = 3'd0;
            end else if (clr) begin
                state_next  = ST_WAIT;
                relock_next = 3'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state_next  = lock_s ? ST_LOCKED : ST_WAIT;
                        relock_next = 3'd0;
                    end
                    ST_WAIT: begin
                        if (rise_q)       state_next = ST_LOCKED;
                        else if (timeout) state_next = ST_FAULT;
                    end
                    ST_LOCKED: begin
                        if (fall_q) state_next = ST_LOST;
                    end
                    ST_LOST: begin
                        if (rise_q) begin
                            if (relock_cnt < RELOCK_LIM) begin
                                state_next  = ST_LOCKED;
                                relock_next = relock_cnt + 3'd1;
                            end else begin
                                state_next = ST_FAULT;
                            end
                        end else if (timeout) begin
                            state_next = ST_FAULT;
                        end
                    end
                    ST_FAULT: state_next = ST_FAULT;
                    default:  state_next = ST_IDLE;
                endcase
            end
        end

        assign locked[g]          = (state == ST_LOCKED);
        assign err_chk[g]         = (state == ST_LOST) || (state == ST_FAULT);
        assign fault[g]           = (state == ST_FAULT);
        assign dbg_state[3*g +: 3] = state;
    end

    assign err_any = |err_chk;

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            results_cnt <= '0;
        end else if (clr) begin
            results_cnt <= '0;
        end else if (chk_en && err_any && (results_cnt != {ERR_CNT_W{1'b1}})) begin
            results_cnt <= results_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_lock_checker.sv
// Self-checking bench for pll_lock_checker: table of timed vectors plus reset and timeout sequences.
// Build with +define+PLL_CHK_TIMEOUT_EN to exercise the timeout variant.
module tb_pll_lock_checker;

    logic        clk_tb;
    logic        rst_n;
    logic [1:0]  pll_lock;
    logic        chk_en;
    logic        clr;
    logic [1:0]  locked;
    logic [1:0]  err_chk;
    logic [1:0]  fault;
    logic        err_any;
    logic [2:0]  results_cnt;
    logic [5:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [9:0] exp_q[$];

    typedef struct {
        int         cyc;
        logic       en;
        logic       clr;
        logic [1:0] lock;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[30];

    pll_lock_checker #(
        .NUM_CH(2), .SYNC_STAGES(3), .RELOCK_MAX(1), .ERR_CNT_W(3), .LOCK_TIMEOUT(100)
    ) dut (
        .clk_tb(clk_tb), .rst_n(rst_n), .pll_lock(pll_lock), .chk_en(chk_en), .clr(clr),
        .locked(locked), .err_chk(err_chk), .fault(fault), .err_any(err_any),
        .results_cnt(results_cnt), .dbg_state(dbg_state)
    );

    initial begin
        clk_tb = 1'b0;
        forever #5 clk_tb = ~clk_tb;
    end

    function automatic vec_t mk(input int cyc, input logic en, input logic c, input logic [1:0] lk,
                                input logic [1:0] l, input logic [1:0] e, input logic [1:0] f,
                                input logic a, input logic [2:0] cnt);
        vec_t v;
        v.cyc  = cyc;
        v.en   = en;
        v.clr  = c;
        v.lock = lk;
        v.exp  = {l, e, f, a, cnt};
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_tb);
        #1;
    endtask

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] act;
        logic [9:0] e;
        exp_q.push_back(exp);
        act = {locked, err_chk, fault, err_any, results_cnt};
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s: got locked=%b err_chk=%b fault=%b err_any=%b cnt=%0d, expected locked=%b err_chk=%b fault=%b err_any=%b cnt=%0d",
                     name, act[9:8], act[7:6], act[5:4], act[3], act[2:0],
                     e[9:8], e[7:6], e[5:4], e[3], e[2:0]);
        end
    endtask

    initial begin
        // Each row: apply inputs, advance cyc edges, then compare.
        vecs[0]  = mk(1, 1, 0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 3'd0); // both enter WAIT
        vecs[1]  = mk(4, 1, 0, 2'b10, 2'b10, 2'b00, 2'b00, 0, 3'd0); // ch1 locks after 5 edges
        vecs[2]  = mk(4, 1, 0, 2'b11, 2'b10, 2'b00, 2'b00, 0, 3'd0); // ch0 one edge short
        vecs[3]  = mk(1, 1, 0, 2'b11, 2'b11, 2'b00, 2'b00, 0, 3'd0); // ch0 locked
        vecs[4]  = mk(4, 1, 0, 2'b10, 2'b11, 2'b00, 2'b00, 0, 3'd0); // drop not yet seen
        vecs[5]  = mk(1, 1, 0, 2'b10, 2'b10, 2'b01, 2'b00, 1, 3'd0); // LOST entry
        vecs[6]  = mk(1, 1, 0, 2'b10, 2'b10, 2'b01, 2'b00, 1, 3'd1);
        vecs[7]  = mk(6, 1, 0, 2'b10, 2'b10, 2'b01, 2'b00, 1, 3'd7); // saturates
        vecs[8]  = mk(8, 1, 0, 2'b10, 2'b10, 2'b01, 2'b00, 1, 3'd7);
        vecs[9]  = mk(4, 1, 0, 2'b11, 2'b10, 2'b01, 2'b00, 1, 3'd7); // last LOST cycle
        vecs[10] = mk(1, 1, 0, 2'b11, 2'b11, 2'b00, 2'b00, 0, 3'd7); // relock after 20 LOST cycles
        vecs[11] = mk(5, 1, 0, 2'b10, 2'b10, 2'b01, 2'b00, 1, 3'd7); // second loss
        vecs[12] = mk(5, 1, 0, 2'b10, 2'b10, 2'b01, 2'b00, 1, 3'd7);
        vecs[13] = mk(4, 1, 0, 2'b11, 2'b10, 2'b01, 2'b00, 1, 3'd7);
        vecs[14] = mk(1, 1, 0, 2'b11, 2'b10, 2'b01, 2'b01, 1, 3'd7); // relock budget spent
        vecs[15] = mk(5, 1, 0, 2'b11, 2'b10, 2'b01, 2'b01, 1, 3'd7); // sticky
        vecs[16] = mk(1, 1, 1, 2'b11, 2'b00, 2'b00, 2'b00, 0, 3'd0); // clr -> WAIT
        vecs[17] = mk(3, 1, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 3'd0); // no new rise, stay WAIT
        vecs[18] = mk(1, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 3'd0); // IDLE
        vecs[19] = mk(1, 1, 0, 2'b11, 2'b11, 2'b00, 2'b00, 0, 3'd0); // IDLE straight to LOCKED
        vecs[20] = mk(4, 1, 0, 2'b10, 2'b11, 2'b00, 2'b00, 0, 3'd0);
        vecs[21] = mk(1, 1, 1, 2'b10, 2'b00, 2'b00, 2'b00, 0, 3'd0); // clr wins over fall
        vecs[22] = mk(2, 1, 0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 3'd0);
        vecs[23] = mk(4, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 3'd0);
        vecs[24] = mk(1, 1, 0, 2'b11, 2'b11, 2'b00, 2'b00, 0, 3'd0);
        vecs[25] = mk(5, 1, 0, 2'b10, 2'b10, 2'b01, 2'b00, 1, 3'd0);
        vecs[26] = mk(2, 1, 0, 2'b10, 2'b10, 2'b01, 2'b00, 1, 3'd2);
        vecs[27] = mk(1, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 3'd2); // count holds when disabled
        vecs[28] = mk(4, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 3'd2);
        vecs[29] = mk(1, 1, 0, 2'b11, 2'b11, 2'b00, 2'b00, 0, 3'd2);

        rst_n    = 1'b0;
        chk_en   = 1'b0;
        clr      = 1'b0;
        pll_lock = 2'b00;
        #1;
        check("reset_initial", 10'd0);
        tick(2);
        check("reset_held", 10'd0);

        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            chk_en   = vecs[i].en;
            clr      = vecs[i].clr;
            pll_lock = vecs[i].lock;
            tick(vecs[i].cyc);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end
        clr = 1'b0;

        // Asynchronous reset while both channels are locked.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 10'd0);
        tick(2);
        check("async_reset_held", 10'd0);
        rst_n = 1'b1;
        tick(4);
        check("post_reset_edge4", 10'd0);
        tick(1);
        check("post_reset_edge5", {2'b11, 2'b00, 2'b00, 1'b0, 3'd0});

        // ch1 never locks.
        rst_n    = 1'b0;
        pll_lock = 2'b01;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("timer_wait_entry", 10'd0);
        tick(99);
        check("timer_edge99", {2'b01, 2'b00, 2'b00, 1'b0, 3'd0});
        tick(1);
`ifdef PLL_CHK_TIMEOUT_EN
        check("timer_edge100", {2'b01, 2'b10, 2'b10, 1'b1, 3'd0});
        tick(1);
        check("timer_edge101", {2'b01, 2'b10, 2'b10, 1'b1, 3'd1});
`else
        check("timer_edge100", {2'b01, 2'b00, 2'b00, 1'b0, 3'd0});
        tick(1);
        check("timer_edge101", {2'b01, 2'b00, 2'b00, 1'b0, 3'd0});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_lock_checker.md
PLL_LOCK_CHECKER -- requirements
Module: pll_lock_checker

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independently checked PLL lock inputs (1..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 3: synchroniser depth per channel (2..4).
REQ-003 SHALL have parameter RELOCK_MAX, default 1: relock events tolerated per channel before fault (0..7).
REQ-004 SHALL have parameter ERR_CNT_W, default 3: width of results_cnt (2..16).
REQ-005 SHALL have parameter LOCK_TIMEOUT, default 1000: clk_tb cycles allowed in WAIT/LOST (only with PLL_CHK_TIMEOUT_EN).
REQ-006 SHALL have port clk_tb, input, 1: checker clock, all state on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port pll_lock, input, NUM_CH: asynchronous lock indicators, bit i = channel i.
REQ-009 SHALL have port chk_en, input, 1: checking enable, synchronous to clk_tb.
REQ-010 SHALL have port clr, input, 1: synchronous clear of faults, relock counts and results_cnt.
REQ-011 SHALL have port locked, output, NUM_CH: channel i in LOCKED.
REQ-012 SHALL have port err_chk, output, NUM_CH: channel i in LOST or FAULT.
REQ-013 SHALL have port fault, output, NUM_CH: channel i in FAULT (sticky).
REQ-014 SHALL have port err_any, output, 1: OR of err_chk.
REQ-015 SHALL have port results_cnt, output, ERR_CNT_W: saturating count of cycles with err_any high.

Function
REQ-016 Each channel SHALL pass pll_lock[i] through SYNC_STAGES flops to lock_s, plus one flop lock_d; rise = lock_s & ~lock_d, fall = ~lock_s & lock_d.
REQ-017 Each channel SHALL run FSM states IDLE, WAIT, LOCKED, LOST, FAULT, all outputs decoded directly from state registers.
REQ-018 Any state -> IDLE when chk_en=0; IDLE -> WAIT when chk_en=1.
REQ-019 WAIT -> LOCKED on rise; or LOCKED directly from IDLE if lock_s=1 on entry cycle.
REQ-020 LOCKED -> LOST on fall.
REQ-021 LOST on rise: relock_cnt<RELOCK_MAX -> LOCKED with relock_cnt+1; else -> FAULT.
REQ-022 FAULT SHALL be held until clr=1, rst_n=0, or chk_en=0.
REQ-023 Latency: pll_lock change stable before edge 1 SHALL be reflected in state/outputs after edge SYNC_STAGES+2.
REQ-024 relock_cnt SHALL be 3 bits per channel, cleared in IDLE and on clr.
REQ-025 results_cnt SHALL increment by 1 on each edge with err_any=1, saturate at all-ones, never wrap.
REQ-026 results_cnt SHALL hold (not clear) while chk_en=0.
REQ-027 clr SHALL take priority over same-cycle rise/fall: all channels -> WAIT (chk_en=1) or IDLE, relock_cnt=0, results_cnt=0.
REQ-028 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be processed the same cycle.

Reset
REQ-029 rst_n=0 SHALL immediately clear sync flops, lock_d, relock_cnt, timers, results_cnt, and set every FSM to IDLE.
REQ-030 During reset locked, err_chk, fault, err_any SHALL be 0 and results_cnt SHALL be 0; reset mid-operation discards all history.

Configuration
REQ-031 With macro PLL_CHK_TIMEOUT_EN defined, each channel SHALL have a timer counting cycles in WAIT or LOST, cleared on leaving them, forcing FAULT when it reaches LOCK_TIMEOUT.
REQ-032 Without PLL_CHK_TIMEOUT_EN, no timer logic SHALL exist; WAIT and LOST SHALL wait indefinitely; LOCK_TIMEOUT unused.

Verification (NUM_CH=2, SYNC_STAGES=3, RELOCK_MAX=1, ERR_CNT_W=3, LOCK_TIMEOUT=100)
REQ-033 chk_en=1, pll_lock[0] rises before edge 10 -> locked[0]=1 after edge 14, err_any stays 0, results_cnt=0.
REQ-034 Locked ch0 drops for 20 cycles then relocks -> err_chk[0] high 20 cycles, back to LOCKED, results_cnt saturates at 7.
REQ-035 Second drop+relock on ch0 -> fault[0]=1 sticky after relock; clr pulse -> fault[0]=0, results_cnt=0, ch0 WAIT.
REQ-036 Macro defined, ch1 never locks -> fault[1]=1 exactly 100 cycles after WAIT entry; macro undefined -> ch1 stays WAIT, fault[1]=0.
REQ-037 rst_n pulled low while both LOCKED -> all outputs 0 without a clk_tb edge; after release both reach LOCKED after SYNC_STAGES+2 edges.
REQ-038 clr on same edge that ch0 fall reaches FSM -> ch0 WAIT, err_chk[0]=0, results_cnt=0.
